// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the controller
// that drives it.
package md_pkg;

   typedef enum logic [2:0] {
      MD_IDLE,
      MD_MULT,
      MD_DIV,
      MD_FIX,
      MD_DONE
   } md_state_t;

   localparam logic MD_OP_MULT = 1'b0;
   localparam logic MD_OP_DIV  = 1'b1;

   // MIPS R-type funct codes decoded by the controller to raise MDControl.
   localparam logic [5:0] MULT = 6'b011000;
   localparam logic [5:0] DIV  = 6'b011010;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV: one bit per cycle on operand magnitudes, then a
// sign-fix cycle that loads hi/lo and a one-cycle done pulse.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_t          state;
   logic [CW-1:0]      cnt;
   logic               sa, sb, op_r, dz;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;

   logic [WIDTH-1:0]   mag_a_in, mag_b_in;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   function automatic logic [WIDTH-1:0] cond_neg_w(input logic en, input logic [WIDTH-1:0] v);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic en, input logic [2*WIDTH-1:0] v);
      return en ? (~v + 1'b1) : v;
   endfunction

   // acc holds {upper, lower}: MULT = {partial product, multiplier},
   // DIV = {partial remainder, dividend shifting into quotient}.
   always_comb begin
      mag_a_in  = cond_neg_w(a[WIDTH-1], a);
      mag_b_in  = cond_neg_w(b[WIDTH-1], b);
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      div_ge    = (div_shift >= {1'b0, mag_b});
      prod_fix  = cond_neg_2w(sa ^ sb, acc);
      quo_fix   = cond_neg_w(sa ^ sb, acc[WIDTH-1:0]);
      rem_fix   = cond_neg_w(sa, acc[2*WIDTH-1:WIDTH]);
   end

   assign busy = (state != MD_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         op_r     <= 1'b0;
         dz       <= 1'b0;
         mag_b    <= '0;
         acc      <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               done     <= 1'b0;
               div_zero <= 1'b0;
               if (start) begin
                  sa    <= a[WIDTH-1];
                  sb    <= b[WIDTH-1];
                  op_r  <= op;
                  mag_b <= mag_b_in;
                  acc   <= {{WIDTH{1'b0}}, mag_a_in};
                  cnt   <= '0;
                  dz    <= (op == MD_OP_DIV) && (b == '0);
                  // A zero divisor passes through FIX (without loading) so
                  // done lands one edge later than the start edge.
                  if (op == MD_OP_MULT)
                     state <= MD_MULT;
                  else if (b == '0)
                     state <= MD_FIX;
                  else
                     state <= MD_DIV;
               end
            end
            MD_MULT: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1))
                  state <= MD_FIX;
            end
            MD_DIV: begin
               if (div_ge)
                  acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else
                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1))
                  state <= MD_FIX;
            end
            MD_FIX: begin
               if (!dz) begin
                  if (op_r == MD_OP_MULT) begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end
               done     <= 1'b1;
               div_zero <= dz;
               state    <= MD_DONE;
            end
            MD_DONE: begin
               done     <= 1'b0;
               div_zero <= 1'b0;
               state    <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule
